// File: rtl/symbol_packer_if.sv
// Symbol-in / word-out handshake bundle for symbol_packer.
// slave = packer side, master = symbol source / word consumer side.
interface symbol_packer_if #(
    parameter int SYM_W    = 2,
    parameter int MAX_SYMS = 4,
    parameter int LEN_W    = $clog2(MAX_SYMS + 1)
);
    logic                      enable;
    logic                      in_valid;
    logic [SYM_W-1:0]          in_sym;
    logic                      in_ready;
    logic                      flush;
    logic [SYM_W*MAX_SYMS-1:0] out_word;
    logic [LEN_W-1:0]          out_len;
    logic                      out_ovf;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output enable, in_valid, in_sym, flush, out_ready,
        input  in_ready, out_word, out_len, out_ovf, out_valid
    );

    modport slave (
        input  enable, in_valid, in_sym, flush, out_ready,
        output in_ready, out_word, out_len, out_ovf, out_valid
    );
endinterface

// File: rtl/symbol_packer.sv
// Packs up to MAX_SYMS Morse symbols (first symbol in MSBs) into one word with length/overflow.
// Optional macro SYMBOL_PACKER_AUTO_FLUSH_EN: a word closes itself when its last slot fills.
module symbol_packer #(
    parameter int SYM_W    = 2,
    parameter int MAX_SYMS = 4,
    parameter int LEN_W    = $clog2(MAX_SYMS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    symbol_packer_if.slave  bus
);
    localparam logic [0:0]       FILL    = 1'b0;
    localparam logic [0:0]       HOLD    = 1'b1;
    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_SYMS);

    logic [0:0]                       state_reg;
    logic [LEN_W-1:0]                 count_reg;
    logic [LEN_W-1:0]                 count_next;
    logic                             ovf_reg;
    logic                             ovf_next;
    logic [MAX_SYMS-1:0][SYM_W-1:0]   slot_reg;
    logic [MAX_SYMS-1:0][SYM_W-1:0]   slot_next;
    logic [SYM_W*MAX_SYMS-1:0]        word_next;
    logic [SYM_W*MAX_SYMS-1:0]        out_word_reg;
    logic [LEN_W-1:0]                 out_len_reg;
    logic                             out_ovf_reg;
    logic                             sym_acc;
    logic                             flush_acc;
    logic                             full;
    logic                             auto_close;
    logic                             close;

    always_comb begin
        sym_acc    = bus.enable && bus.in_valid && (state_reg == FILL);
        flush_acc  = bus.enable && bus.flush && (state_reg == FILL);
        full       = (count_reg == MAX_CNT);
        count_next = (sym_acc && !full) ? count_reg + LEN_W'(1) : count_reg;
        ovf_next   = ovf_reg | (sym_acc && full);
`ifdef SYMBOL_PACKER_AUTO_FLUSH_EN
        auto_close = sym_acc && (count_reg == MAX_CNT - LEN_W'(1));
`else
        auto_close = 1'b0;
`endif
        // A flush that lands on an empty word produces nothing.
        close = (flush_acc && (count_next != '0)) || auto_close;
    end

    // Slot 0 maps to the MSBs so the first symbol received leads the word.
    generate
        for (genvar gi = 0; gi < MAX_SYMS; gi++) begin : g_slot
            assign slot_next[gi] = (sym_acc && (count_reg == LEN_W'(gi))) ? bus.in_sym
                                                                           : slot_reg[gi];
            assign word_next[SYM_W*(MAX_SYMS-gi)-1 -: SYM_W] = slot_next[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= FILL;
            count_reg    <= '0;
            ovf_reg      <= 1'b0;
            slot_reg     <= '0;
            out_word_reg <= '0;
            out_len_reg  <= '0;
            out_ovf_reg  <= 1'b0;
        end else if (state_reg == FILL) begin
            if (close) begin
                out_word_reg <= word_next;
                out_len_reg  <= count_next;
                out_ovf_reg  <= ovf_next;
                // Clearing slots keeps unused low slots of the next word at zero.
                count_reg    <= '0;
                ovf_reg      <= 1'b0;
                slot_reg     <= '0;
                state_reg    <= HOLD;
            end else begin
                count_reg    <= count_next;
                ovf_reg      <= ovf_next;
                slot_reg     <= slot_next;
            end
        end else if (bus.out_ready) begin
            state_reg <= FILL;
        end
    end

    assign bus.in_ready  = (state_reg == FILL);
    assign bus.out_valid = (state_reg == HOLD);
    assign bus.out_word  = out_word_reg;
    assign bus.out_len   = out_len_reg;
    assign bus.out_ovf   = out_ovf_reg;
endmodule

// File: tb/tb_symbol_packer.sv
// Directed + random bench for symbol_packer against a queue-based reference model.
module tb_symbol_packer;
    localparam int SYM_W    = 2;
    localparam int MAX_SYMS = 4;
    localparam int LEN_W    = $clog2(MAX_SYMS + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    symbol_packer_if #(.SYM_W(SYM_W), .MAX_SYMS(MAX_SYMS), .LEN_W(LEN_W)) bus ();

    symbol_packer #(.SYM_W(SYM_W), .MAX_SYMS(MAX_SYMS), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending symbols, drop flag, and the word on offer.
    int q[$];
    bit m_ovf  = 1'b0;
    bit m_hold = 1'b0;
    int m_word = 0;
    int m_len  = 0;
    bit m_ovfo = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/out_valid"}, 32'(bus.out_valid), 32'(m_hold));
        check({tag, "/in_ready"},  32'(bus.in_ready),  32'(!m_hold));
        check({tag, "/out_word"},  32'(bus.out_word),  32'(m_word));
        check({tag, "/out_len"},   32'(bus.out_len),   32'(m_len));
        check({tag, "/out_ovf"},   32'(bus.out_ovf),   32'(m_ovfo));
    endtask

    function automatic void model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_hold = 1'b0;
        m_word = 0;
        m_len  = 0;
        m_ovfo = 1'b0;
    endfunction

    function automatic void model_step(bit en, bit iv, int sym, bit fl, bit ordy);
        bit close;
        if (m_hold) begin
            if (ordy) begin
                $display("xfer word=%02h len=%0d ovf=%0d", m_word, m_len, m_ovfo);
                m_hold = 1'b0;
            end
        end else begin
            close = 1'b0;
            if (en && iv) begin
                if (q.size() < MAX_SYMS) q.push_back(sym);
                else m_ovf = 1'b1;
`ifdef SYMBOL_PACKER_AUTO_FLUSH_EN
                if (q.size() == MAX_SYMS) close = 1'b1;
`endif
            end
            if (en && fl && q.size() > 0) close = 1'b1;
            if (close) begin
                m_word = 0;
                foreach (q[i]) m_word |= q[i] << (SYM_W * (MAX_SYMS - 1 - i));
                m_len  = q.size();
                m_ovfo = m_ovf;
                q.delete();
                m_ovf  = 1'b0;
                m_hold = 1'b1;
            end
        end
    endfunction

    task automatic step(input bit en, input bit iv, input int sym, input bit fl,
                        input bit ordy, input string tag);
        bus.enable    = en;
        bus.in_valid  = iv;
        bus.in_sym    = SYM_W'(sym);
        bus.flush     = fl;
        bus.out_ready = ordy;
        model_step(en, iv, sym, fl, ordy);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Reset asserted between edges: outputs must clear before any clock arrives.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        model_reset();
        #2;
        check_all({tag, "_async"});
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_all({tag, "_release"});
    endtask

    initial begin
        bus.enable    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sym    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        model_reset();
        #3;
        check_all("reset");
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Full word 1,2,3,1
        step(1, 1, 1, 0, 1, "t1_s0");
        step(1, 1, 2, 0, 1, "t1_s1");
        step(1, 1, 3, 0, 1, "t1_s2");
        step(1, 1, 1, 0, 1, "t1_s3");
`ifndef SYMBOL_PACKER_AUTO_FLUSH_EN
        step(1, 0, 0, 1, 1, "t1_flush");
`endif
        check("t1_word", 32'(bus.out_word), 32'h6D);
        check("t1_len",  32'(bus.out_len),  32'd4);
        check("t1_ovf",  32'(bus.out_ovf),  32'd0);
        step(1, 0, 0, 0, 1, "t1_idle");
        check("t1_ready_back", 32'(bus.in_ready), 32'd1);

        // Flush alone, and symbol plus flush together
        step(1, 1, 2, 0, 1, "t2_s0");
        step(1, 1, 3, 0, 1, "t2_s1");
        step(1, 0, 0, 1, 1, "t2_flush");
        check("t2_word", 32'(bus.out_word), 32'hB0);
        check("t2_len",  32'(bus.out_len),  32'd2);
        step(1, 0, 0, 0, 1, "t2_idle");
        step(1, 1, 1, 0, 1, "t3_s0");
        step(1, 1, 3, 1, 1, "t3_symflush");
        check("t3_word", 32'(bus.out_word), 32'h70);
        check("t3_len",  32'(bus.out_len),  32'd2);
        step(1, 0, 0, 0, 1, "t3_idle");

        // Empty flush and disabled inputs
        step(1, 0, 0, 1, 1, "t4_empty_flush");
        step(0, 1, 2, 1, 1, "t4_disabled");
        step(1, 1, 1, 0, 1, "t4_s0");
        step(0, 1, 3, 1, 1, "t4_disabled2");
        step(1, 0, 0, 1, 1, "t4_flush");
        check("t4_word", 32'(bus.out_word), 32'h40);
        check("t4_len",  32'(bus.out_len),  32'd1);
        step(1, 0, 0, 0, 1, "t4_idle");

        // Backpressure with ignored input pulses
        step(1, 1, 1, 0, 0, "t5_s0");
        step(1, 1, 2, 0, 0, "t5_s1");
        step(1, 0, 0, 1, 0, "t5_flush");
        for (int i = 0; i < 5; i++) step(1, i % 2, 3, i % 2, 0, "t5_stall");
        check("t5_word", 32'(bus.out_word), 32'h60);
        step(0, 0, 0, 0, 1, "t5_release");
        step(1, 1, 3, 1, 1, "t5_next");
        check("t5_next_word", 32'(bus.out_word), 32'hC0);
        check("t5_next_len",  32'(bus.out_len),  32'd1);
        step(1, 0, 0, 0, 1, "t5_idle");

        // Overflow: six symbols into a four-slot word
        step(1, 1, 1, 0, 1, "t6_s0");
        step(1, 1, 1, 0, 1, "t6_s1");
        step(1, 1, 1, 0, 1, "t6_s2");
        step(1, 1, 1, 0, 1, "t6_s3");
        step(1, 1, 2, 0, 1, "t6_s4");
        step(1, 1, 3, 0, 1, "t6_s5");
        step(1, 0, 0, 1, 1, "t6_flush");
`ifndef SYMBOL_PACKER_AUTO_FLUSH_EN
        check("t6_word", 32'(bus.out_word), 32'h55);
        check("t6_len",  32'(bus.out_len),  32'd4);
        check("t6_ovf",  32'(bus.out_ovf),  32'd1);
`endif
        step(1, 0, 0, 0, 1, "t6_idle");
        step(1, 1, 2, 1, 1, "t6_next");
        check("t6_next_word", 32'(bus.out_word), 32'h80);
        check("t6_next_ovf",  32'(bus.out_ovf),  32'd0);
        step(1, 0, 0, 0, 1, "t6_idle2");

        // Reset mid-word and during HOLD
        step(1, 1, 1, 0, 1, "t7_s0");
        step(1, 1, 2, 0, 1, "t7_s1");
        do_reset("t7_rst_fill");
        step(1, 1, 3, 1, 1, "t7_after");
        check("t7_word", 32'(bus.out_word), 32'hC0);
        check("t7_len",  32'(bus.out_len),  32'd1);
        step(1, 0, 0, 0, 1, "t7_idle");
        step(1, 1, 1, 1, 0, "t7_hold");
        do_reset("t7_rst_hold");
        step(1, 1, 2, 1, 1, "t7_after2");
        check("t7_word2", 32'(bus.out_word), 32'h80);
        step(1, 0, 0, 0, 1, "t7_idle2");

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) do_reset("rnd_rst");
            else step(($urandom % 8) != 0, $urandom % 2, int'($urandom % 4),
                      ($urandom % 5) == 0, ($urandom % 3) != 0, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
